// File: rtl/updown_counter_param.sv
// Purpose : parametrised synchronous up/down counter with clear, load, wrap/saturate and status flags.
// Latency : one clk from clr/load/en to q; wrap is registered and pulses the cycle after a boundary event.
// Backpressure: none; en gates counting, and clr > load > en resolve conflicting requests.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - asynchronous active-high reset (q <= RST_VAL, wrap <= 0)
//   clr      - synchronous clear to RST_VAL
//   load     - synchronous parallel load of load_val (clamped to MAX_COUNT)
//   load_val - value to load
//   en       - count enable
//   up_down  - 1 = count up, 0 = count down
//   q        - current count
//   tc       - terminal count for the current direction (combinational)
//   wrap     - one-cycle registered pulse after a wrap or saturation hit
//   at_max   - q == MAX_COUNT
//   at_zero  - q == 0
module updown_counter_param #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] load_clamped;

  // Out-of-range loads are pinned to MAX_COUNT so q can never leave 0..MAX_COUNT.
  assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  assign at_max  = (q == MAX_COUNT);
  assign at_zero = (q == ZERO);
  assign tc      = (up_down & at_max) | (~up_down & at_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_VAL;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= RST_VAL;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_clamped;
      wrap <= 1'b0;
    end else if (en) begin
      if (up_down) begin
        // Boundary is tested before incrementing, so a non-power-of-two
        // MAX_COUNT yields modulus MAX_COUNT+1 without overflowing WIDTH.
        if (at_max) begin
          wrap <= 1'b1;
          if (!SATURATE) q <= ZERO;
        end else begin
          q    <= q + ONE;
          wrap <= 1'b0;
        end
      end else begin
        if (at_zero) begin
          wrap <= 1'b1;
          if (!SATURATE) q <= MAX_COUNT;
        end else begin
          q    <= q - ONE;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up_down;

  // d0: defaults (MAX 15, wrap), d1: MAX 9 wrap, d2: MAX 9 saturate
  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       wrap0, wrap1, wrap2;
  logic       amax0, amax1, amax2;
  logic       azero0, azero1, azero2;

  int checks;
  int failures;

  updown_counter_param #(.WIDTH(4)) d0 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_down(up_down), .q(q0), .tc(tc0), .wrap(wrap0),
    .at_max(amax0), .at_zero(azero0)
  );

  updown_counter_param #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) d1 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_down(up_down), .q(q1), .tc(tc1), .wrap(wrap1),
    .at_max(amax1), .at_zero(azero1)
  );

  updown_counter_param #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) d2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_down(up_down), .q(q2), .tc(tc2), .wrap(wrap2),
    .at_max(amax2), .at_zero(azero2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    en       = 1'b0;
    up_down  = 1'b1;

    // Reset state
    #12;
    check("rst_q0", q0, 0);
    check("rst_wrap0", wrap0, 0);
    check("rst_at_zero0", azero0, 1);
    check("rst_at_max0", amax0, 0);
    check("rst_tc0_up", tc0, 0);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    up_down = 1'b1;

    // Full up count 1..15, then wrap to 0
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("up_q0", q0, i);
      check("up_wrap0", wrap0, 0);
    end
    check("up15_tc0", tc0, 1);
    check("up15_at_max0", amax0, 1);
    tick();
    check("wrap_q0", q0, 0);
    check("wrap_pulse0", wrap0, 1);
    tick();
    check("after_wrap_q0", q0, 1);
    check("after_wrap_pulse0", wrap0, 0);

    // Clear (beats en), then count down from 0 on MAX 9 wrap counter
    clr = 1'b1;
    tick();
    check("clr_q1", q1, 0);
    check("clr_wrap1", wrap1, 0);
    check("clr_at_zero2", azero2, 1);
    clr = 1'b0;
    up_down = 1'b0;
    #1;
    check("dn_tc1_at0", tc1, 1);
    tick();
    check("dn_wrap_q1", q1, 9);
    check("dn_wrap_pulse1", wrap1, 1);
    check("dn_at_max1", amax1, 1);
    check("dn_at_zero1", azero1, 0);
    tick();
    check("dn_q1_8", q1, 8);
    check("dn_wrap1_8", wrap1, 0);
    check("dn_at_max1_8", amax1, 0);
    tick();
    check("dn_q1_7", q1, 7);

    // Saturating counter: load 7, count up 5 times
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd7;
    tick();
    check("ld7_q2", q2, 7);
    load = 1'b0;
    en = 1'b1;
    up_down = 1'b1;
    tick();
    check("sat_q2_a", q2, 8);
    check("sat_wrap2_a", wrap2, 0);
    tick();
    check("sat_q2_b", q2, 9);
    check("sat_wrap2_b", wrap2, 0);
    check("sat_tc2_b", tc2, 1);
    check("sat_at_max2_b", amax2, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_q2_hold", q2, 9);
      check("sat_wrap2_hold", wrap2, 1);
    end

    // Clamped load, then clr beats load and en
    load = 1'b1;
    load_val = 4'd12;
    tick();
    check("ld12_q2_clamp", q2, 9);
    check("ld12_q1_clamp", q1, 9);
    check("ld12_q0", q0, 12);
    check("ld12_wrap2", wrap2, 0);
    clr = 1'b1;
    tick();
    check("clr_prio_q0", q0, 0);
    check("clr_prio_q2", q2, 0);
    clr = 1'b0;
    load = 1'b0;

    // Count up to 5, then async reset between edges
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_q0", q0, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q0", q0, 0);
    check("async_rst_wrap0", wrap0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_q0", q0, 1);

    // Load 6, then direction change on successive edges
    load = 1'b1;
    load_val = 4'd6;
    tick();
    check("ld6_q0", q0, 6);
    load = 1'b0;
    up_down = 1'b0;
    tick();
    check("dir_dn_q0", q0, 5);
    up_down = 1'b1;
    tick();
    check("dir_up_q0", q0, 6);

    // Hold with en=0 while toggling direction
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_down = ~up_down;
      #1;
      check("hold_tc0_comb", tc0, 0);
      tick();
      check("hold_q0", q0, 6);
      check("hold_wrap0", wrap0, 0);
      check("hold_tc0", tc0, 0);
      check("hold_q1", q1, 6);
      check("hold_tc1", tc1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised, fully synchronous up/down counter. Next generation of the 4-bit ripple T-flip-flop up/down counter.
- Adds configurable width and modulus, count enable, synchronous clear and parallel load, a wrap or saturate mode, and terminal-count/wrap status outputs.
- Used as a general event/timer counter in datapath and FSM blocks where the ripple version's skew is not acceptable.

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- MAX_COUNT, 2**WIDTH-1, highest count value; must be <= 2**WIDTH-1 and >= 1.
- SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends.
- RST_VAL, 0, value loaded on reset and on clr; must be <= MAX_COUNT.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to RST_VAL.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- q  output  WIDTH  current count.
- tc  output  1  terminal count: high while q is at the end of the current direction.
- wrap  output  1  one-cycle pulse, registered, on the cycle after a wrap or a saturation hit.
- at_max  output  1  high when q == MAX_COUNT (combinational from q).
- at_zero  output  1  high when q == 0 (combinational from q).

Behaviour:
- Reset: rst=1 forces, asynchronously, q=RST_VAL and wrap=0. tc, at_max and at_zero follow from q. Deassertion is synchronised externally.
- Priority per rising edge: rst > clr > load > en. Lower-priority inputs are ignored in that cycle.
- clr=1: q <= RST_VAL, wrap <= 0.
- load=1:
  - q <= load_val if load_val <= MAX_COUNT, else q <= MAX_COUNT (clamped).
  - wrap <= 0.
- en=1 and up_down=1:
  - q < MAX_COUNT: q <= q+1.
  - q == MAX_COUNT: SATURATE=0 gives q <= 0 and wrap <= 1; SATURATE=1 gives q held and wrap <= 1.
- en=1 and up_down=0:
  - q > 0: q <= q-1.
  - q == 0: SATURATE=0 gives q <= MAX_COUNT and wrap <= 1; SATURATE=1 gives q held and wrap <= 1.
- en=0 (no clr/load): q holds, wrap <= 0.
- wrap is high for exactly one cycle per boundary event. In saturate mode it re-asserts every enabled cycle that attempts to pass the end.
- tc = (up_down & at_max) | (~up_down & at_zero). It is combinational, so a direction change moves tc in the same cycle.
- Latency: one clock from en/load/clr to the q update. No combinational path from load_val to q.
- Arithmetic:
  - The increment is WIDTH bits wide. The MAX_COUNT compare happens before the increment, so q never exceeds MAX_COUNT.
  - A non-power-of-two MAX_COUNT gives a modulus of MAX_COUNT+1.
- Direction change mid-count takes effect on the next enabled edge, with no extra cycle.
- rst asserted mid-count overrides everything immediately. The count resumes from RST_VAL after release.

Test Plan:
- WIDTH=4, default params: rst pulse, then en=1, up_down=1 for 17 cycles. Expect q 0→15, tc=1 at q=15, then q=0 with wrap=1 for one cycle; q continues 0,1.
- WIDTH=4, MAX_COUNT=9, SATURATE=0, q=0, en=1, up_down=0. Expect q=9 after one edge with wrap pulse, then 8, 7. at_max=1 only at 9.
- SATURATE=1, MAX_COUNT=9: count up from 7 for 5 cycles. Expect q 8, 9, 9, 9, 9, with wrap=1 on each cycle after an attempt at 9.
- load=1 with load_val=12, MAX_COUNT=9. Expect q=9. Then load, clr and en all high together: expect q=RST_VAL (clr wins).
- Counting up, q=5: assert rst between clock edges. Expect q=0 immediately (before the next edge) and wrap=0. After release with en=1: q=1.
- en=0 for 3 cycles at q=6 while toggling up_down. Expect q stays 6, wrap stays 0, and tc stays 0.
